mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Device-side peripheral for the core's whole-word memory-mapped ports.
- Takes a command word from one core MMIO output register and returns a status word to one core MMIO input register.
- Buffers bytes in a small FIFO and serialises them as 8N1 UART frames on txd.
- Core MMIO writes carry no strobe, so new requests are signalled by a toggle bit.
- Runs on the core clock; no clock-domain crossing.

Parameters:
- CLOCKS_PER_BIT, 434: clock cycles per serial bit (50 MHz / 115200). Legal range >= 2.
- FIFO_DEPTH_LOG2, 2: FIFO holds 2^FIFO_DEPTH_LOG2 bytes. Legal range 1..4.

Ports:
- clock  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0), sampled on the rising edge of clock.
- commandWord  input  32  driven from a core MMIO output register. [7:0] = data byte; [31] = request toggle; other bits ignored.
- statusWord  output  32  drives a core MMIO input register.
- txd  output  1  UART serial data; idle high.

Behaviour:
- Status word layout:
  - [31] ackToggle
  - [30] busy (FSM not IDLE or FIFO not empty)
  - [29] full
  - [28] empty
  - [4:0] count (FIFO occupancy, 0..2^FIFO_DEPTH_LOG2)
  - all other bits 0
  - statusWord is combinational from registered state only.
- Reset (reset==0 at an edge), regardless of current state, including mid-frame:
  - ackToggle=0, FIFO emptied (count=0), FSM=IDLE, baud counter=0, txd=1.
  - statusWord therefore reads 0x10000000.
- Request acceptance:
  - A request is pending when commandWord[31] != ackToggle.
  - At an edge where a request is pending and the FIFO is not full (or a pop happens on the same edge): push commandWord[7:0] and set ackToggle=commandWord[31].
  - If the FIFO is full and no pop occurs, the request stays pending, nothing is pushed, and ackToggle is unchanged. The request is accepted on the first edge with space.
  - Exactly one push per toggle change; a constant commandWord never pushes twice.
  - Changes to bits [7:0] without a toggle change are ignored.
  - If commandWord[31]=1 when reset deasserts, that is a pending request and it is accepted.
- Software protocol: write {toggle', byte}, then poll until status[31]==toggle'.
- FIFO:
  - Circular buffer; pointers wrap modulo depth.
  - Simultaneous push and pop leaves count unchanged, including when full or when count==1.
  - Pop from empty never occurs.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If FIFO not empty at an edge, pop the head into the shift register, set baud counter=0 and bitIndex=0, go to START.
  - START: txd=0 for CLOCKS_PER_BIT cycles, then go to DATA.
  - DATA: txd=shift[0], LSB first. Every CLOCKS_PER_BIT cycles shift right and increment bitIndex. After bit 7's period, go to STOP.
  - STOP: txd=1 for CLOCKS_PER_BIT cycles. At the end of the period, if FIFO not empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Baud counter counts 0..CLOCKS_PER_BIT-1 and wraps to 0 at each bit boundary. Width is $clog2(CLOCKS_PER_BIT).
- Latency, with toggle change visible before edge E0:
  - push and ack occur at E0
  - pop and START entry occur at E1
  - txd falls after E1
- Frame length: 10*CLOCKS_PER_BIT cycles. With the optional feature enabled: 11*CLOCKS_PER_BIT.
- txd is driven from a register (glitch-free).

Optional Feature:
- Macro: MMIO_UART_TX_PARITY_EN
- Defined:
  - Adds state PARITY between DATA and STOP, lasting CLOCKS_PER_BIT cycles.
  - txd = XOR of the 8 data bits XOR commandWord[30], latched at push time per FIFO entry. So commandWord[30]=0 gives even parity and 1 gives odd parity.
  - FIFO width becomes 9 bits.
  - statusWord[27] = 1 (reports parity capable).
- Undefined:
  - 8N1 only; commandWord[30] is ignored and statusWord[27]=0.

Test Plan:
- Bench uses CLOCKS_PER_BIT=4, FIFO_DEPTH_LOG2=2.
- Reset, commandWord=0: statusWord=0x10000000 and txd=1; holding the input constant for 100 cycles gives no push.
- commandWord 0x00000000 -> 0x80000055 -> status[31]=1 and count=1 after E0. txd=0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles. Final status 0x90000000.
- Six toggled writes (0x11..0x16) each issued as soon as ack matches: ack stalls while full (count=4, status[29]=1). All six bytes appear in order with frames back-to-back, each 40 cycles, no idle gap.
- Full FIFO with pending request at the STOP-end pop edge: push and pop are simultaneous, count stays 4, ack toggles that same edge.
- Assert reset mid-DATA of byte 0xA5 with 2 bytes queued: txd=1 the next cycle, status=0x10000000, nothing further is transmitted.
- MMIO_UART_TX_PARITY_EN defined, command 0x80000007: parity bit=1, frame 44 cycles. Command 0x40000007 (toggle back to 0, odd): parity bit=0.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO-driven UART transmitter for the core's whole-word ports.
// A toggle in commandWord[31] requests a push of commandWord[7:0] into a small
// FIFO; the ack toggle in statusWord[31] follows once the byte is accepted.
// Bytes are serialised LSB first as 8N1 frames on txd.
// Optional build macro: MMIO_UART_TX_PARITY_EN adds a parity bit per frame
// (commandWord[30] selects odd parity) and sets statusWord[27].
module mmio_uart_tx #(
  parameter int unsigned CLOCKS_PER_BIT  = 434,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] commandWord,
  output logic [31:0] statusWord,
  output logic        txd
);

  localparam int unsigned DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W  = FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned BAUD_W = $clog2(CLOCKS_PER_BIT);
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int unsigned ENTRY_W = 9;
`else
  localparam int unsigned ENTRY_W = 8;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_ack;

  logic [BAUD_W-1:0]    r_baud;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 r_txd;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_busy;
  logic                 w_pending;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_last_data;
  logic                 w_shift_en;
  logic                 w_txd_next;
  logic [ENTRY_W-1:0]   w_wr_data;
  logic [ENTRY_W-1:0]   w_head;
  logic                 w_par_cap;
  logic                 w_unused_cmd;

`ifdef MMIO_UART_TX_PARITY_EN
  logic                 r_par;

  // Parity is fixed per entry when the byte is accepted
  assign w_wr_data    = {(^commandWord[7:0]) ^ commandWord[30], commandWord[7:0]};
  assign w_par_cap    = 1'b1;
  assign w_unused_cmd = ^commandWord[29:8];
`else
  assign w_wr_data    = commandWord[7:0];
  assign w_par_cap    = 1'b0;
  assign w_unused_cmd = ^commandWord[30:8];
`endif

  // FIFO flags and request handshake
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_pending   = (commandWord[31] != r_ack);
  assign w_push      = w_pending && (!w_full || w_pop);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_busy      = (r_state != S_IDLE) || !w_empty;
  assign w_bit_end   = (r_baud == BAUD_W'(CLOCKS_PER_BIT - 1));
  assign w_last_data = (r_bit_idx == 3'd7);

  // Status word is built only from registered state
  assign statusWord = {r_ack, w_busy, w_full, w_empty, w_par_cap, 22'd0, 5'(r_count)};
  assign txd        = r_txd;

  // Transmit FSM state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Transmit FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_next = S_START;
      end
      S_START: begin
        if (w_bit_end) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && w_last_data) begin
`ifdef MMIO_UART_TX_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
      S_PARITY: begin
        if (w_bit_end) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) w_state_next = w_empty ? S_IDLE : S_START;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Transmit FSM outputs: pop, shift and the next line level
  always_comb begin
    w_pop      = 1'b0;
    w_shift_en = 1'b0;
    w_txd_next = 1'b1;
    case (r_state)
      S_IDLE:  w_pop      = !w_empty;
      S_DATA:  w_shift_en = w_bit_end && !w_last_data;
      S_STOP:  w_pop      = w_bit_end && !w_empty;
      default: ;
    endcase
    case (w_state_next)
      S_START: w_txd_next = 1'b0;
      S_DATA:  w_txd_next = w_shift_en ? r_shift[1] : r_shift[0];
`ifdef MMIO_UART_TX_PARITY_EN
      S_PARITY: w_txd_next = r_par;
`endif
      default: w_txd_next = 1'b1;
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_data;
  end

  // FIFO pointers, occupancy and ack toggle
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ack    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_ack    <= commandWord[31];
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Baud counter, shift register, bit index and registered txd
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_txd <= w_txd_next;
      if (w_pop) begin
        r_baud    <= '0;
        r_bit_idx <= '0;
        r_shift   <= w_head[7:0];
      end else if (r_state != S_IDLE) begin
        r_baud <= w_bit_end ? '0 : r_baud + BAUD_W'(1);
        if (w_shift_en) begin
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end
    end
  end

`ifdef MMIO_UART_TX_PARITY_EN
  // Parity bit of the frame in flight
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_par <= 1'b0;
    end else if (w_pop) begin
      r_par <= w_head[8];
    end
  end
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized and directed bench for mmio_uart_tx with a
// frame-level reference model (byte queue plus a frame countdown timer).
module tb_mmio_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DL2   = 2;
  localparam int unsigned DEPTH = 1 << DL2;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int unsigned FRAME = 11 * CPB;
  localparam logic        CAP   = 1'b1;
`else
  localparam int unsigned FRAME = 10 * CPB;
  localparam logic        CAP   = 1'b0;
`endif
  localparam logic [31:0] RST_STATUS = {3'b000, 1'b1, CAP, 27'd0};

  logic        clock;
  logic        reset;
  logic [31:0] commandWord;
  logic [31:0] statusWord;
  logic        txd;

  int unsigned n_checks;
  int unsigned n_pass;
  logic        tog;

  mmio_uart_tx #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DL2)) dut (
    .clock       (clock),
    .reset       (reset),
    .commandWord (commandWord),
    .statusWord  (statusWord),
    .txd         (txd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: queue of pending entries, frame timer for the byte in flight
  logic [8:0]  m_q [$];
  logic [8:0]  m_cur;
  logic        m_ack;
  int unsigned m_left;
  logic        m_started;
  logic        m_pop;
  logic        m_pend;

  initial begin
    m_ack = 1'b0; m_left = 0; m_started = 1'b0; m_cur = '0;
  end

  always @(posedge clock) begin
    if (!reset) begin
      m_q.delete();
      m_ack  = 1'b0;
      m_left = 0;
    end else begin
      m_pend = (commandWord[31] != m_ack);
      m_pop  = (m_q.size() > 0) && (m_left <= 1);
      if (m_left > 0) m_left--;
      if (m_pop) begin
        m_cur  = m_q.pop_front();
        m_left = FRAME;
      end
      if (m_pend && m_q.size() < DEPTH) begin
        m_q.push_back({(^commandWord[7:0]) ^ commandWord[30], commandWord[7:0]});
        m_ack = commandWord[31];
      end
    end
    m_started = 1'b1;
  end

  function automatic logic exp_txd();
    int unsigned b;
    if (m_left == 0) return 1'b1;
    b = (FRAME - m_left) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
`ifdef MMIO_UART_TX_PARITY_EN
    if (b == 9) return m_cur[8];
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    int unsigned n;
    n = m_q.size();
    return {m_ack, (m_left > 0) || (n > 0), n == DEPTH, n == 0, CAP, 22'd0, 5'(n)};
  endfunction

  // Cycle-by-cycle comparison against the model, plus a few observations
  logic        full_seen;
  logic        simul_seen;
  logic [31:0] prev_status;
  initial begin full_seen = 1'b0; simul_seen = 1'b0; prev_status = '0; end

  always @(negedge clock) begin
    if (m_started) begin
      check_eq("status", statusWord, exp_status());
      check_eq("txd", 32'(txd), 32'(exp_txd()));
      if (statusWord[29]) full_seen = 1'b1;
      if (prev_status[4:0] == 5'd4 && statusWord[4:0] == 5'd4 &&
          prev_status[31] != statusWord[31]) simul_seen = 1'b1;
      prev_status = statusWord;
    end
  end

  task automatic write_cmd(input logic [7:0] b, input logic p);
    int unsigned c;
    tog = ~tog;
    commandWord = {tog, p, 22'd0, b};
    c = 0;
    do begin
      @(negedge clock);
      c++;
    end while (statusWord[31] != tog && c < 2000);
    if (statusWord[31] != tog) check_eq("ack_timeout", 32'(statusWord[31]), 32'(tog));
  endtask

  task automatic wait_idle();
    int unsigned c;
    c = 0;
    while (statusWord[30] && c < 5000) begin
      @(negedge clock);
      c++;
    end
    check_eq("idle", 32'(statusWord[30]), 32'd0);
  endtask

  // Sends one byte from idle, checks frame length and the bit after the data
  task automatic frame_check(input logic [7:0] b, input logic p);
    int unsigned c;
    logic        bit9;
    wait_idle();
    write_cmd(b, p);
    c = 0;
    bit9 = 1'bx;
    while (statusWord[30] && c < 1000) begin
      @(negedge clock);
      c++;
      if (c == 9 * CPB + 2) bit9 = txd;
    end
    check_eq("frame_len", c, FRAME + 1);
`ifdef MMIO_UART_TX_PARITY_EN
    check_eq("parity_bit", 32'(bit9), 32'((^b) ^ p));
`else
    check_eq("stop_bit", 32'(bit9), 32'd1);
`endif
  endtask

  initial begin
    n_checks = 0; n_pass = 0; tog = 1'b0;
    reset = 1'b0;
    commandWord = 32'd0;

    // Reset state and no push on a constant command
    repeat (3) @(negedge clock);
    check_eq("rst_status", statusWord, RST_STATUS);
    check_eq("rst_txd", 32'(txd), 32'd1);
    reset = 1'b1;
    repeat (100) @(negedge clock);
    check_eq("hold_status", statusWord, RST_STATUS);

    // Single byte 0x55
    write_cmd(8'h55, 1'b0);
    check_eq("e0_ack", 32'(statusWord[31]), 32'd1);
    check_eq("e0_count", 32'(statusWord[4:0]), 32'd1);
    wait_idle();
    check_eq("final_status", statusWord, {4'b1001, CAP, 27'd0});

    // Six back-to-back bytes with the FIFO running full
    for (int i = 0; i < 6; i++) write_cmd(8'h11 + 8'(i), 1'b0);
    wait_idle();
    check_eq("full_seen", 32'(full_seen), 32'd1);
    check_eq("push_pop_full", 32'(simul_seen), 32'd1);

    // Reset mid-DATA of 0xA5 with two bytes queued
    write_cmd(8'hA5, 1'b0);
    write_cmd(8'hB1, 1'b0);
    write_cmd(8'hC2, 1'b0);
    repeat (8) @(negedge clock);
    reset = 1'b0;
    commandWord = 32'd0;
    tog = 1'b0;
    @(negedge clock);
    check_eq("midrst_txd", 32'(txd), 32'd1);
    check_eq("midrst_status", statusWord, RST_STATUS);
    reset = 1'b1;
    repeat (100) @(negedge clock);
    check_eq("post_rst_status", statusWord, RST_STATUS);

    // Randomized writes, data-only changes and idle gaps
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) commandWord[7:0] = 8'($urandom);
      else write_cmd(8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 50)) @(negedge clock);
    end
    wait_idle();

    // Parity / stop bit and frame length for byte 0x07 in both modes
    frame_check(8'h07, 1'b0);
    frame_check(8'h07, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
